// File: rtl/nco_sweep_controller.sv
// ---------------------------------------------------------------------------
// nco_sweep_controller
//
// Drives the 32-bit NCO frequency word. On a start request it latches the
// sweep settings, emits the start word, then steps the word upward by a fixed
// increment, holding each word for max(dwell,1) cycles. The sweep ends on
// carry out, on passing the stop word, or on a zero step. Single mode pulses
// opDone and returns to idle; continuous mode pulses opWrap and restarts at
// the start word.
//
// Optional feature macro: NCO_SWEEP_TRIANGLE_EN
//   Adds ipTriangle. When latched high, reaching the up-sweep end turns the
//   sweep around and steps down until the next word would fall below the
//   start word or borrow.
//
// Ports:
//   ipClk         system clock
//   ipReset       asynchronous active-high reset
//   ipStartFreq   first frequency word (unsigned)
//   ipStopFreq    inclusive upper bound (unsigned)
//   ipStep        increment per step (unsigned)
//   ipDwell       cycles each word is held, 0 treated as 1
//   ipContinuous  1 = repeating sweeps, 0 = one sweep
//   ipTriangle    up/down sweep select (NCO_SWEEP_TRIANGLE_EN only)
//   ipStart       single-cycle start request, ignored while busy
//   ipAbort       single-cycle abort request, wins over start and sweep end
//   opFrequency   registered frequency word to the NCO
//   opBusy        high while a sweep runs
//   opDone        one-cycle pulse when a single sweep completes
//   opWrap        one-cycle pulse when a continuous sweep restarts
// ---------------------------------------------------------------------------
module nco_sweep_controller #(
   parameter int DWELL_W = 16
) (
   input  logic               ipClk,
   input  logic               ipReset,
   input  logic [31:0]        ipStartFreq,
   input  logic [31:0]        ipStopFreq,
   input  logic [31:0]        ipStep,
   input  logic [DWELL_W-1:0] ipDwell,
   input  logic               ipContinuous,
`ifdef NCO_SWEEP_TRIANGLE_EN
   input  logic               ipTriangle,
`endif
   input  logic               ipStart,
   input  logic               ipAbort,
   output logic [31:0]        opFrequency,
   output logic               opBusy,
   output logic               opDone,
   output logic               opWrap
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t             r_state;
   logic [31:0]        r_freq;
   logic [31:0]        r_start;
   logic [31:0]        r_stop;
   logic [31:0]        r_step;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [DWELL_W-1:0] r_dwell_ld;
   logic               r_cont;
   logic               r_busy;
   logic               r_done;
   logic               r_wrap;

   logic [32:0]        w_up_sum;
   logic               w_up_end;
   logic               w_end;
   logic [31:0]        w_next_freq;
   logic               w_dwell_last;
   logic [DWELL_W-1:0] w_dwell_in;

`ifdef NCO_SWEEP_TRIANGLE_EN
   logic               r_tri;
   logic               r_down;
   logic [32:0]        w_dn_diff;
   logic               w_dn_end;
   logic               w_next_down;
`endif

   // Counter holds remaining cycles minus one, so a dwell of 0 or 1 both
   // reload 0 and the word changes every cycle.
   assign w_dwell_in   = (ipDwell == '0) ? '0 : ipDwell - DWELL_W'(1);
   assign w_dwell_last = (r_dwell_cnt == '0);

   // NOTE: every signal gets a default at the top of always_comb; a path that
   // skips an assignment would otherwise infer a latch.
   always_comb begin
      // 33-bit add: bit 32 is the carry that stops the word wrapping to 0.
      w_up_sum    = {1'b0, r_freq} + {1'b0, r_step};
      w_up_end    = w_up_sum[32] || (w_up_sum[31:0] > r_stop) || (r_step == 32'd0);
      w_end       = w_up_end;
      w_next_freq = w_up_sum[31:0];
`ifdef NCO_SWEEP_TRIANGLE_EN
      w_dn_diff   = {1'b0, r_freq} - {1'b0, r_step};
      w_dn_end    = w_dn_diff[32] || (w_dn_diff[31:0] < r_start) || (r_step == 32'd0);
      w_next_down = 1'b0;
      // Already descending, or at the top of a triangle: take the down step
      // straight from the current word so the stop word appears only once.
      if (r_down || (w_up_end && r_tri)) begin
         w_end       = w_dn_end;
         w_next_freq = w_dn_diff[31:0];
         w_next_down = 1'b1;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         // NOTE: the latched sweep settings are reset along with the state so
         // no X ever reaches the compare/add logic.
         r_state     <= ST_IDLE;
         r_freq      <= '0;
         r_start     <= '0;
         r_stop      <= '0;
         r_step      <= '0;
         r_dwell_cnt <= '0;
         r_dwell_ld  <= '0;
         r_cont      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wrap      <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
         r_tri       <= 1'b0;
         r_down      <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_wrap <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Abort in the same cycle suppresses the start.
               if (ipStart && !ipAbort) begin
                  r_start     <= ipStartFreq;
                  r_stop      <= ipStopFreq;
                  r_step      <= ipStep;
                  r_cont      <= ipContinuous;
                  r_dwell_ld  <= w_dwell_in;
                  r_dwell_cnt <= w_dwell_in;
                  r_freq      <= ipStartFreq;
                  r_busy      <= 1'b1;
                  r_state     <= ST_RUN;
`ifdef NCO_SWEEP_TRIANGLE_EN
                  r_tri       <= ipTriangle;
                  r_down      <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               if (ipAbort) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_freq      <= '0;
                  r_dwell_cnt <= '0;
               end else if (!w_dwell_last) begin
                  r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
               end else if (!w_end) begin
                  r_freq      <= w_next_freq;
                  r_dwell_cnt <= r_dwell_ld;
`ifdef NCO_SWEEP_TRIANGLE_EN
                  r_down      <= w_next_down;
`endif
               end else if (r_cont) begin
                  r_freq      <= r_start;
                  r_wrap      <= 1'b1;
                  r_dwell_cnt <= r_dwell_ld;
`ifdef NCO_SWEEP_TRIANGLE_EN
                  r_down      <= 1'b0;
`endif
               end else begin
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign opFrequency = r_freq;
   assign opBusy      = r_busy;
   assign opDone      = r_done;
   assign opWrap      = r_wrap;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_nco_sweep_controller
//
// Directed bench for nco_sweep_controller. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so each sample shows the
// result of the preceding edge. "Cycle k" is the k-th sample after the edge
// that accepted ipStart.
// ---------------------------------------------------------------------------
module tb_nco_sweep_controller;

   logic        ipClk;
   logic        ipReset;
   logic [31:0] ipStartFreq;
   logic [31:0] ipStopFreq;
   logic [31:0] ipStep;
   logic [15:0] ipDwell;
   logic        ipContinuous;
   logic        ipTriangle;
   logic        ipStart;
   logic        ipAbort;
   logic [31:0] opFrequency;
   logic        opBusy;
   logic        opDone;
   logic        opWrap;

   int n_checks = 0;
   int n_errors = 0;

   nco_sweep_controller #(.DWELL_W(16)) dut (
      .ipClk        (ipClk),
      .ipReset      (ipReset),
      .ipStartFreq  (ipStartFreq),
      .ipStopFreq   (ipStopFreq),
      .ipStep       (ipStep),
      .ipDwell      (ipDwell),
      .ipContinuous (ipContinuous),
`ifdef NCO_SWEEP_TRIANGLE_EN
      .ipTriangle   (ipTriangle),
`endif
      .ipStart      (ipStart),
      .ipAbort      (ipAbort),
      .opFrequency  (opFrequency),
      .opBusy       (opBusy),
      .opDone       (opDone),
      .opWrap       (opWrap)
   );

   initial begin
      ipClk = 1'b0;
      forever #5 ipClk = ~ipClk;
   end

   task automatic tick();
      @(posedge ipClk);
      #1;
   endtask

   // Pulse ipStart for one edge; on return the sample is cycle 1.
   task automatic start_sweep(input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] st, input logic [15:0] d,
                              input logic cont, input logic tri_en);
      ipStartFreq  = s;
      ipStopFreq   = e;
      ipStep       = st;
      ipDwell      = d;
      ipContinuous = cont;
      ipTriangle   = tri_en;
      ipStart      = 1'b1;
      tick();
      ipStart      = 1'b0;
   endtask

   task automatic test_reset();
      ipReset = 1'b1;
      #2;
      n_checks++;
      if ({opFrequency, opBusy, opDone, opWrap} !== 35'd0) begin
         n_errors++;
         $display("FAIL reset outputs: got freq=%0h busy=%b done=%b wrap=%b, want all 0",
                  opFrequency, opBusy, opDone, opWrap);
      end
      tick();
      tick();
      ipReset = 1'b0;
      tick();
      n_checks++;
      if ({opFrequency, opBusy, opDone, opWrap} !== 35'd0) begin
         n_errors++;
         $display("FAIL reset release idle: got freq=%0h busy=%b done=%b wrap=%b, want all 0",
                  opFrequency, opBusy, opDone, opWrap);
      end
   endtask

   // 100..130 step 10 dwell 3: words change every 3 cycles, done at cycle 13.
   task automatic test_single_sweep();
      logic [31:0] exp_f;
      start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
      // Inputs changed after the start must not matter.
      ipStartFreq = 32'd999; ipStopFreq = 32'd5000; ipStep = 32'd1; ipDwell = 16'd9;
      for (int k = 1; k <= 14; k++) begin
         exp_f = (k <= 12) ? 32'd100 + 32'd10 * 32'((k - 1) / 3) : 32'd130;
         n_checks++;
         if (opFrequency !== exp_f || opBusy !== (k <= 12) || opDone !== (k == 13)
             || opWrap !== 1'b0) begin
            n_errors++;
            $display("FAIL single cyc%0d: got freq=%0d busy=%b done=%b wrap=%b, want freq=%0d busy=%b done=%b wrap=0",
                     k, opFrequency, opBusy, opDone, opWrap, exp_f, (k <= 12), (k == 13));
         end
         tick();
      end
   endtask

   // Continuous: wrap every 12 cycles back to 100, never done.
   task automatic test_continuous();
      logic [31:0] exp_f;
      int          m;
      start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b1, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         m     = (k - 1) % 12;
         exp_f = 32'd100 + 32'd10 * 32'(m / 3);
         n_checks++;
         if (opFrequency !== exp_f || opBusy !== 1'b1 || opDone !== 1'b0
             || opWrap !== (k > 1 && m == 0)) begin
            n_errors++;
            $display("FAIL continuous cyc%0d: got freq=%0d busy=%b done=%b wrap=%b, want freq=%0d busy=1 done=0 wrap=%b",
                     k, opFrequency, opBusy, opDone, opWrap, exp_f, (k > 1 && m == 0));
         end
         if (k < 30) tick();
      end
      ipAbort = 1'b1;
      tick();
      ipAbort = 1'b0;
      n_checks++;
      if (opBusy !== 1'b0 || opFrequency !== 32'd0 || opWrap !== 1'b0 || opDone !== 1'b0) begin
         n_errors++;
         $display("FAIL continuous abort: got freq=%0d busy=%b done=%b wrap=%b, want 0/0/0/0",
                  opFrequency, opBusy, opDone, opWrap);
      end
      tick();
   endtask

   task automatic test_dwell_zero();
      logic [31:0] exp_f;
      start_sweep(32'd5, 32'd7, 32'd1, 16'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         exp_f = (k <= 3) ? 32'd4 + 32'(k) : 32'd7;
         n_checks++;
         if (opFrequency !== exp_f || opDone !== (k == 4) || opBusy !== (k <= 3)) begin
            n_errors++;
            $display("FAIL dwell0 cyc%0d: got freq=%0d busy=%b done=%b, want freq=%0d busy=%b done=%b",
                     k, opFrequency, opBusy, opDone, exp_f, (k <= 3), (k == 4));
         end
         tick();
      end
   endtask

   // One dwell (2 cycles) of the start word, then done; used for step=0,
   // start>stop and carry-out cases.
   task automatic test_one_dwell_end(input string name, input logic [31:0] s,
                                     input logic [31:0] e, input logic [31:0] st);
      start_sweep(s, e, st, 16'd2, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (opFrequency !== s || opDone !== (k == 3) || opBusy !== (k <= 2)
             || opWrap !== 1'b0) begin
            n_errors++;
            $display("FAIL %s cyc%0d: got freq=%0h busy=%b done=%b wrap=%b, want freq=%0h busy=%b done=%b wrap=0",
                     name, k, opFrequency, opBusy, opDone, opWrap, s, (k <= 2), (k == 3));
         end
         tick();
      end
   endtask

   task automatic test_abort();
      logic seen_done;
      start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
      tick();                       // cycle 2, mid-dwell of 100
      ipAbort = 1'b1;
      tick();
      ipAbort = 1'b0;
      n_checks++;
      if (opBusy !== 1'b0 || opFrequency !== 32'd0 || opDone !== 1'b0) begin
         n_errors++;
         $display("FAIL abort: got freq=%0d busy=%b done=%b, want 0/0/0",
                  opFrequency, opBusy, opDone);
      end
      seen_done = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (opDone || opWrap || opBusy || opFrequency != 32'd0) seen_done = 1'b1;
         tick();
      end
      n_checks++;
      if (seen_done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort quiet: got activity=%b after abort, want 0", seen_done);
      end
      // Abort while idle does nothing.
      ipAbort = 1'b1;
      tick();
      ipAbort = 1'b0;
      n_checks++;
      if (opBusy !== 1'b0 || opFrequency !== 32'd0 || opDone !== 1'b0) begin
         n_errors++;
         $display("FAIL idle abort: got freq=%0d busy=%b done=%b, want 0/0/0",
                  opFrequency, opBusy, opDone);
      end
   endtask

   task automatic test_abort_start();
      start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
      tick();
      ipStartFreq = 32'd777;
      ipAbort     = 1'b1;
      ipStart     = 1'b1;
      tick();
      ipAbort = 1'b0;
      ipStart = 1'b0;
      n_checks++;
      if (opBusy !== 1'b0 || opFrequency !== 32'd0) begin
         n_errors++;
         $display("FAIL abort+start: got freq=%0d busy=%b, want 0/0", opFrequency, opBusy);
      end
      tick();
      n_checks++;
      if (opBusy !== 1'b0 || opFrequency !== 32'd0) begin
         n_errors++;
         $display("FAIL abort+start after: got freq=%0d busy=%b, want 0/0", opFrequency, opBusy);
      end
   endtask

   task automatic test_start_while_busy();
      start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
      tick(); tick(); tick();       // cycle 4, word 110
      ipStartFreq = 32'd500;
      ipStart     = 1'b1;
      tick();                       // cycle 5
      ipStart = 1'b0;
      n_checks++;
      if (opFrequency !== 32'd110 || opBusy !== 1'b1) begin
         n_errors++;
         $display("FAIL start busy: got freq=%0d busy=%b, want 110/1", opFrequency, opBusy);
      end
      for (int k = 5; k < 13; k++) tick();
      n_checks++;
      if (opDone !== 1'b1 || opFrequency !== 32'd130 || opBusy !== 1'b0) begin
         n_errors++;
         $display("FAIL start busy end: got freq=%0d busy=%b done=%b, want 130/0/1",
                  opFrequency, opBusy, opDone);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      start_sweep(32'd5, 32'd7, 32'd1, 16'd0, 1'b0, 1'b0);
      tick(); tick(); tick();       // cycle 4: done high, word 7 held
      n_checks++;
      if (opDone !== 1'b1 || opFrequency !== 32'd7) begin
         n_errors++;
         $display("FAIL b2b first done: got freq=%0d done=%b, want 7/1", opFrequency, opDone);
      end
      start_sweep(32'd40, 32'd40, 32'd1, 16'd1, 1'b0, 1'b0);
      n_checks++;
      if (opFrequency !== 32'd40 || opBusy !== 1'b1 || opDone !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b restart: got freq=%0d busy=%b done=%b, want 40/1/0",
                  opFrequency, opBusy, opDone);
      end
      tick();
      n_checks++;
      if (opDone !== 1'b1 || opBusy !== 1'b0 || opFrequency !== 32'd40) begin
         n_errors++;
         $display("FAIL b2b second done: got freq=%0d busy=%b done=%b, want 40/0/1",
                  opFrequency, opBusy, opDone);
      end
      tick();
   endtask

   task automatic test_async_reset();
      start_sweep(32'd100, 32'd130, 32'd10, 16'd1, 1'b1, 1'b0);
      tick(); tick();               // word 120, busy
      #3;
      ipReset = 1'b1;
      #1;
      n_checks++;
      if ({opFrequency, opBusy, opDone, opWrap} !== 35'd0) begin
         n_errors++;
         $display("FAIL async reset: got freq=%0d busy=%b done=%b wrap=%b, want all 0",
                  opFrequency, opBusy, opDone, opWrap);
      end
      ipReset = 1'b0;
      tick();
      tick();
      n_checks++;
      if (opBusy !== 1'b0 || opFrequency !== 32'd0) begin
         n_errors++;
         $display("FAIL async reset idle: got freq=%0d busy=%b, want 0/0", opFrequency, opBusy);
      end
   endtask

`ifdef NCO_SWEEP_TRIANGLE_EN
   task automatic test_triangle();
      logic [31:0] exp_f [8];
      exp_f = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd0, 32'd0};
      start_sweep(32'd0, 32'd30, 32'd10, 16'd1, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         n_checks++;
         if (opFrequency !== exp_f[k-1] || opDone !== (k == 8) || opBusy !== (k <= 7)) begin
            n_errors++;
            $display("FAIL triangle cyc%0d: got freq=%0d busy=%b done=%b, want freq=%0d busy=%b done=%b",
                     k, opFrequency, opBusy, opDone, exp_f[k-1], (k <= 7), (k == 8));
         end
         tick();
      end
   endtask
`endif

   initial begin
      ipReset = 1'b1; ipStartFreq = '0; ipStopFreq = '0; ipStep = '0; ipDwell = '0;
      ipContinuous = 1'b0; ipTriangle = 1'b0; ipStart = 1'b0; ipAbort = 1'b0;
      test_reset();
      test_single_sweep();
      test_continuous();
      test_dwell_zero();
      test_one_dwell_end("step0", 32'd50, 32'd100, 32'd0);
      test_one_dwell_end("start_gt_stop", 32'd200, 32'd100, 32'd5);
      test_one_dwell_end("overflow", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20);
      test_abort();
      test_abort_start();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset();
`ifdef NCO_SWEEP_TRIANGLE_EN
      test_triangle();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/nco_sweep_controller.md
# nco_sweep_controller

Sequencer that drives the 32-bit frequency word of the modulator NCO. It steps the word from a start value towards a stop value in fixed increments and holds each value for a programmable dwell. It runs either a single sweep or continuous repeating sweeps. It sits between the modulator control registers and the NCO frequency input, and is the only writer of that input.

## Interface
Parameters:
- DWELL_W, 16, width of the dwell count.

Ports:
- ipClk  in  1  system clock.
- ipReset  in  1  reset, asynchronous, active-high.
- ipStartFreq  in  32  first frequency word, unsigned.
- ipStopFreq  in  32  upper bound of the sweep, unsigned, inclusive.
- ipStep  in  32  increment per step, unsigned.
- ipDwell  in  DWELL_W  cycles each word is held; 0 is treated as 1.
- ipContinuous  in  1  1 restarts the sweep at ipStartFreq after each end; 0 runs one sweep.
- ipStart  in  1  single-cycle start request.
- ipAbort  in  1  single-cycle abort request.
- opFrequency  out  32  frequency word to the NCO.
- opBusy  out  1  high while a sweep is running.
- opDone  out  1  one-cycle pulse when a single sweep completes.
- opWrap  out  1  one-cycle pulse when a continuous sweep restarts.

## Operation
- Reset values: opFrequency=0, opBusy=0, opDone=0, opWrap=0. State is IDLE and the dwell counter is 0.
- ipStartFreq, ipStopFreq, ipStep, ipDwell and ipContinuous are latched on the accepted ipStart. Later input changes have no effect until the next start.
- States:
  - IDLE: on ipStart, load opFrequency=ipStartFreq, load the dwell counter, set opBusy=1, go to RUN.
  - RUN: decrement the dwell counter each cycle. On the last dwell cycle, evaluate the next word as next = freq + step, using 33-bit arithmetic.
  - End of sweep occurs when any of these holds: the carry out is set, next > stop, or step == 0.
  - If it is not the end of the sweep: opFrequency=next and reload the dwell counter.
  - End of sweep with continuous mode: opFrequency=start, opWrap=1 for one cycle, reload the dwell counter, stay in RUN.
  - End of sweep with single mode: opDone=1 for one cycle, opBusy=0, go to IDLE. opFrequency holds the last emitted word.
- If start > stop, the start word is emitted for one dwell, then the sweep ends.
- ipStart while opBusy=1 is ignored.
- ipAbort in RUN: go to IDLE the next cycle with opBusy=0 and opFrequency=0. opDone and opWrap are not pulsed.
- ipAbort has priority over ipStart and over end-of-sweep in the same cycle. ipAbort in IDLE has no effect.
- The word never wraps through 0: an overflowing add ends the sweep.

## Timing
- Start latency: ipStart high at clock edge N gives opFrequency=start and opBusy=1 after edge N.
- Each word is present for exactly max(ipDwell,1) cycles, with no gap between words.
- opDone and opWrap assert in the first cycle after the final dwell cycle. opBusy falls in the same cycle as opDone.
- A new ipStart is accepted in the cycle opDone is high (state is already IDLE), giving back-to-back sweeps with a one-cycle hold of the last word.
- Asynchronous reset takes effect mid-sweep immediately. All outputs go to their reset values.
- Outputs are registered with no combinational path from inputs to outputs.

## Configuration
- NCO_SWEEP_TRIANGLE_EN defined:
  - Adds input ipTriangle (1 bit), latched on ipStart.
  - With ipTriangle=1, on reaching the up-sweep end the controller steps down by ipStep until next < start or borrow occurs. It then ends the sweep or wraps as above.
  - The stop word is emitted only once, at the turnaround.
- NCO_SWEEP_TRIANGLE_EN undefined: the port is absent and only the up-sweep behaviour exists.

## Test plan
- Single sweep: start=100, stop=130, step=10, dwell=3. Expect opFrequency 100,110,120,130, each held 3 cycles. opDone is pulsed on cycle 13 after start, opBusy falls, and opFrequency holds 130.
- Continuous sweep: same settings with ipContinuous=1. Expect opWrap pulses every 12 cycles, opFrequency returns to 100, and opDone is never seen.
- Boundaries:
  - dwell=0 with step=1, start=5, stop=7: expect 5,6,7 on consecutive cycles.
  - step=0: expect a single dwell of start, then opDone.
  - start=200, stop=100: expect one dwell of 200, then opDone.
- Overflow: start=0xFFFFFFF0, step=0x20, stop=0xFFFFFFFF. Expect one dwell of 0xFFFFFFF0, then opDone with no wrap to low values.
- Abort and restart:
  - ipAbort mid-dwell: expect opBusy=0 and opFrequency=0 next cycle, with no opDone.
  - Simultaneous ipAbort and ipStart: abort wins.
  - ipStart while busy: ignored.
  - Asynchronous reset mid-sweep: all outputs 0 immediately.
- With NCO_SWEEP_TRIANGLE_EN: start=0, stop=30, step=10, dwell=1, ipTriangle=1. Expect 0,10,20,30,20,10,0, then opDone.
